// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - segment bit positions and hex-to-segment decode for the display scanner
package sseg_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_DP = 7;
    localparam int SEG_A  = 6;
    localparam int SEG_B  = 5;
    localparam int SEG_C  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 2;
    localparam int SEG_F  = 1;
    localparam int SEG_G  = 0;

    localparam seg_t SEG_ABCDEFG = seg_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                          (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                          (1 << SEG_G));

    // Entry n sits at bits [8n+7:8n]; F is the leftmost byte.
    localparam logic [127:0] SEG_HEX_TABLE = {
        8'h47, 8'h4F, 8'h3D, 8'h0D, 8'h1F, 8'h77, 8'h7B, 8'h7F,
        8'h70, 8'h5F, 8'h5B, 8'h33, 8'h79, 8'h6D, 8'h30, 8'h7E
    };

    function automatic seg_t sseg_hex(input logic [3:0] nibble);
        return SEG_HEX_TABLE[{nibble, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sseg_lzb.sv
// rtl/sseg_lzb.sv - leading-zero suppression mask derived from the frame snapshot
module sseg_lzb #(
    parameter int N_DIG = 8
) (
    input  logic [4*N_DIG-1:0] dat,
    input  logic               lzb,
    output logic [N_DIG-1:0]   sup
);

    logic zero_above;

    // Walk from the most significant digit down; digit 0 always stays lit.
    always_comb begin
        zero_above = 1'b1;
        sup        = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            zero_above = zero_above && (dat[4*k +: 4] == 4'h0);
            sup[k]     = lzb && zero_above && (k != 0);
        end
    end

endmodule

// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - multiplexed seven-segment scanner with snapshot, blanking and PWM dimming
module sseg_scan #(
    parameter int N_DIG       = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] dat,
    input  logic [N_DIG-1:0]   dp,
    input  logic [N_DIG-1:0]   blank,
    input  logic               lzb,
    input  logic [3:0]         bright,
    output logic [7:0]         seg,
    output logic [N_DIG-1:0]   an,
    output logic               frame
);
    import sseg_pkg::*;

    localparam int IDX_W = $clog2(N_DIG);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam seg_t             SEG_INV  = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIG-1:0] AN_INV   = AN_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic [PRE_W-1:0]   pre;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         pwm;
    logic [3:0]         bright_s;
    logic [4*N_DIG-1:0] dat_s;
    logic [N_DIG-1:0]   dp_s;
    logic [N_DIG-1:0]   blank_s;
    logic               lzb_s;

    logic               tc;
    logic               frame_load;
    logic               guard;
    logic [N_DIG-1:0]   sup;
    logic [N_DIG-1:0]   onehot;
    logic [3:0]         nib;
    logic               dp_cur;
    logic               off_cur;
    seg_t               seg_log;
    logic [N_DIG-1:0]   an_log;

    assign tc         = (pre == PRE_LAST);
    assign frame_load = tc && (idx == IDX_LAST);
    // First cycle of every digit slot is forced dark so the previous digit never ghosts.
    assign guard      = (pre == '0);

    sseg_lzb #(
        .N_DIG (N_DIG)
    ) u_lzb (
        .dat (dat_s),
        .lzb (lzb_s),
        .sup (sup)
    );

    always_comb begin
        nib     = 4'h0;
        onehot  = '0;
        dp_cur  = 1'b0;
        off_cur = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx == IDX_W'(i)) begin
                nib       = dat_s[4*i +: 4];
                onehot[i] = 1'b1;
                dp_cur    = dp_s[i];
                off_cur   = blank_s[i] || sup[i];
            end
        end
    end

    always_comb begin
        seg_log = off_cur ? 8'h00 : (sseg_hex(nib) & SEG_ABCDEFG);
        seg_log[SEG_DP] = dp_cur;
        an_log  = (!guard && (pwm <= bright_s)) ? onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre      <= '0;
            idx      <= '0;
            pwm      <= 4'h0;
            bright_s <= 4'h0;
            dat_s    <= '0;
            dp_s     <= '0;
            blank_s  <= '0;
            lzb_s    <= 1'b0;
            frame    <= 1'b0;
            seg      <= SEG_INV;
            an       <= AN_INV;
        end else begin
            pre      <= tc ? '0 : pre + 1'b1;
            pwm      <= pwm + 4'h1;
            bright_s <= bright;
            frame    <= frame_load;
            if (tc) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (frame_load) begin
                dat_s   <= dat;
                dp_s    <= dp;
                blank_s <= blank;
                lzb_s   <= lzb;
            end
            seg <= seg_log ^ SEG_INV;
            an  <= an_log ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// tb/tb_sseg_scan.sv - self-checking bench for sseg_scan against a time-indexed reference model
module tb_sseg_scan;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] dat;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzb;
    logic [3:0]  bright;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        frame_a, frame_b;

    sseg_scan #(.N_DIG(N), .REFRESH_DIV(RD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .dat(dat), .dp(dp), .blank(blank), .lzb(lzb),
        .bright(bright), .seg(seg_a), .an(an_a), .frame(frame_a)
    );

    sseg_scan #(.N_DIG(N), .REFRESH_DIV(RD), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .dat(dat), .dp(dp), .blank(blank), .lzb(lzb),
        .bright(bright), .seg(seg_b), .an(an_b), .frame(frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                                 8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h0D, 8'h3D, 8'h4F, 8'h47};

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_frame = -1;

    // Model: mc = cycles since reset release; snapshot and bright history as plain values.
    int          mc = 0;
    logic [15:0] s_dat   = '0;
    logic [3:0]  s_dp    = '0;
    logic [3:0]  s_blank = '0;
    logic        s_lzb   = 1'b0;
    logic [3:0]  b_hist  = '0;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_frame;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int d, ph, p;
        logic [3:0] nv;
        logic lead;
        if (!rst_n) begin
            exp_seg = 8'h00; exp_an = 4'h0; exp_frame = 1'b0;
            mc = 0; s_dat = '0; s_dp = '0; s_blank = '0; s_lzb = 1'b0; b_hist = '0;
        end else begin
            d    = (mc / RD) % N;
            ph   = mc % RD;
            p    = mc % 16;
            nv   = 4'(s_dat >> (4 * d));
            lead = s_lzb && (d != 0) && ((s_dat >> (4 * d)) == 16'h0);
            exp_seg    = (s_blank[d] || lead) ? 8'h00 : hex_tab[nv];
            exp_seg[7] = s_dp[d];
            exp_an     = (ph != 0 && p <= int'(b_hist)) ? 4'(1 << d) : 4'h0;
            exp_frame  = (mc % (N * RD)) == (N * RD - 1);
            if (exp_frame) begin
                s_dat = dat; s_dp = dp; s_blank = blank; s_lzb = lzb;
            end
            b_hist = bright;
            mc++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check("seg", seg_a, exp_seg);
            check("an", {4'h0, an_a}, {4'h0, exp_an});
            check("frame", {7'h0, frame_a}, {7'h0, exp_frame});
            check("seg_pin_inv", seg_b, ~exp_seg);
            check("an_pin_inv", {4'h0, an_b}, {4'h0, ~exp_an});
            check("frame_inv", {7'h0, frame_b}, {7'h0, exp_frame});
            if (!rst_n) begin
                last_frame = -1;
            end else if (frame_a === 1'b1) begin
                if (last_frame >= 0) check("frame_gap", 8'(cyc - last_frame), 8'(N * RD));
                last_frame = cyc;
            end
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; dat = '0; dp = '0; blank = '0; lzb = 1'b0; bright = 4'h0;
        run(3);
        check("rst_seg_inv_pins", seg_b, 8'hFF);
        check("rst_an_inv_pins", {4'h0, an_b}, 8'h0F);

        rst_n = 1'b1; dat = 16'h1234; bright = 4'hF;
        run(48);

        while (((mc / RD) % N) != 2) run(1);
        dat = 16'hABCD;
        run(36);

        dat = 16'h0050; lzb = 1'b1;
        run(32);
        dat = 16'h0000;
        run(32);

        lzb = 1'b0; blank = 4'b0010; dp = 4'b0010; dat = 16'h8888;
        run(32);

        blank = '0; dp = '0; dat = 16'($urandom); bright = 4'd3;
        run(48);
        bright = 4'd0;
        run(48);

        repeat (40) begin
            dat    = 16'($urandom);
            dp     = 4'($urandom);
            blank  = 4'($urandom);
            lzb    = 1'($urandom);
            bright = 4'($urandom);
            run($urandom_range(1, 20));
        end

        bright = 4'hF; dat = 16'h1234; dp = '0; blank = '0; lzb = 1'b0;
        run(20);
        while (((mc / RD) % N) != 2) run(1);
        rst_n = 1'b0;
        run(1);
        check("midrst_seg", seg_a, 8'h00);
        check("midrst_an", {4'h0, an_a}, 8'h00);
        check("midrst_seg_inv", seg_b, 8'hFF);
        check("midrst_an_inv", {4'h0, an_b}, 8'h0F);
        rst_n = 1'b1;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
